ov7670_capture_dec: RTL and testbench

//  Parametrised successor to the OV7670 pixel capture stage. Samples the camera bus
//  (pclk/href/vsync/d) in the clk domain and pairs bytes into pixels (RGB565 or YUV422

---
 rtl/ov7670_capture_dec.sv | 221 ++++++++++++++++++++++
 tb/tb_ov7670_capture_dec.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_capture_dec.sv
// ov7670_capture_dec: OV7670 bus sampler, byte pairing, power-of-2 decimation and crop into frame buffer port A.
// Revision 1.0
`default_nettype none

module ov7670_capture_dec #(
  parameter int IMG_COLS   = 160,
  parameter int IMG_ROWS   = 120,
  parameter int NB_ADDR    = 15,
  parameter int NB_R       = 4,
  parameter int NB_G       = 4,
  parameter int NB_B       = 4,
  parameter int NB_SRC_CNT = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pclk,
  input  logic                     vsync,
  input  logic                     href,
  input  logic [7:0]               data,
  input  logic                     rgbmode,
  input  logic                     swap_r_b,
  input  logic [1:0]               dec_x,
  input  logic [1:0]               dec_y,
  input  logic [1:0]               cap_mode,
  input  logic                     arm,
  output logic [NB_ADDR-1:0]       addr,
  output logic [NB_R+NB_G+NB_B-1:0] dout,
  output logic                     we,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     line_err
);

  localparam int NB_PIX = NB_R + NB_G + NB_B;
  localparam logic [NB_SRC_CNT-1:0] COLS_LIM = NB_SRC_CNT'(IMG_COLS);
  localparam logic [NB_SRC_CNT-1:0] ROWS_LIM = NB_SRC_CNT'(IMG_ROWS);
  localparam logic [NB_ADDR-1:0]    ROW_STEP = NB_ADDR'(IMG_COLS);

  typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE, DONE} state_t;

  state_t state;

  logic [1:0] pclk_sync, href_sync, vsync_sync;
  logic [7:0] data_meta, data_sync;
  logic       pclk_q, href_q, vsync_q;

  logic                  armed;
  logic                  toggle;
  logic [7:0]            b0;
  logic [NB_SRC_CNT-1:0] src_col, src_row;
  logic [NB_ADDR-1:0]    row_base;
  logic                  cfg_rgb, cfg_swap;
  logic [1:0]            cfg_dx, cfg_dy;

  logic pclk_rise, href_fall, vs_fall, vs_rise;

  assign pclk_rise = pclk_sync[1] & ~pclk_q;
  assign href_fall = ~href_sync[1] & href_q;
  assign vs_fall   = ~vsync_sync[1] & vsync_q;
  assign vs_rise   = vsync_sync[1] & ~vsync_q;

  // Channel extraction keeps the MSBs of each field.
  logic [4:0]      r5, b5;
  logic [5:0]      g6;
  logic [NB_R-1:0] r_t;
  logic [NB_G-1:0] g_t;
  logic [NB_B-1:0] b_t;
  logic [NB_PIX-1:0] pix;

  assign r5 = b0[7:3];
  assign g6 = {b0[2:0], data_sync[7:5]};
  assign b5 = data_sync[4:0];

  always_comb begin
    r_t = '0;
    g_t = '0;
    b_t = '0;
    if (cfg_rgb) begin
      r_t = NB_R'(r5 >> (5 - NB_R));
      g_t = NB_G'(g6 >> (6 - NB_G));
      b_t = NB_B'(b5 >> (5 - NB_B));
    end else begin
      r_t = NB_R'(b0 >> (8 - NB_R));
      g_t = NB_G'(b0 >> (8 - NB_G));
      b_t = NB_B'(b0 >> (8 - NB_B));
    end
  end

  generate
    if (NB_R == NB_B) begin : g_swap
      assign pix = cfg_swap ? {b_t, g_t, r_t} : {r_t, g_t, b_t};
    end else begin : g_noswap
      assign pix = {r_t, g_t, b_t};
    end
  endgenerate

  logic [NB_SRC_CNT-1:0] col_mask, row_mask, out_col, out_row;
  logic                  col_keep, row_keep, in_crop;
  logic [NB_ADDR-1:0]    pix_addr;

  assign col_mask = ~({NB_SRC_CNT{1'b1}} << cfg_dx);
  assign row_mask = ~({NB_SRC_CNT{1'b1}} << cfg_dy);
  assign out_col  = src_col >> cfg_dx;
  assign out_row  = src_row >> cfg_dy;
  assign col_keep = (src_col & col_mask) == '0;
  assign row_keep = ((src_row & row_mask) == '0) && (out_row < ROWS_LIM);
  assign in_crop  = (out_col < COLS_LIM);
  assign pix_addr = row_base + NB_ADDR'(out_col);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pclk_sync  <= '0;
      href_sync  <= '0;
      vsync_sync <= '0;
      data_meta  <= '0;
      data_sync  <= '0;
      pclk_q     <= 1'b0;
      href_q     <= 1'b0;
      vsync_q    <= 1'b0;
      armed      <= 1'b0;
      toggle     <= 1'b0;
      b0         <= '0;
      src_col    <= '0;
      src_row    <= '0;
      row_base   <= '0;
      cfg_rgb    <= 1'b0;
      cfg_swap   <= 1'b0;
      cfg_dx     <= '0;
      cfg_dy     <= '0;
      addr       <= '0;
      dout       <= '0;
      we         <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      line_err   <= 1'b0;
    end else begin
      pclk_sync  <= {pclk_sync[0], pclk};
      href_sync  <= {href_sync[0], href};
      vsync_sync <= {vsync_sync[0], vsync};
      data_meta  <= data;
      data_sync  <= data_meta;
      pclk_q     <= pclk_sync[1];
      href_q     <= href_sync[1];
      vsync_q    <= vsync_sync[1];

      we         <= 1'b0;
      frame_done <= 1'b0;

      if (arm) begin
        armed    <= 1'b1;
        line_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cap_mode == 2'b00 || (cap_mode == 2'b01 && armed))
            state <= WAIT_VS;
        end
        WAIT_VS: begin
          if (cap_mode[1]) begin
            state <= IDLE;
          end else if (vs_fall) begin
            state    <= ACTIVE;
            busy     <= 1'b1;
            cfg_rgb  <= rgbmode;
            cfg_swap <= swap_r_b;
            cfg_dx   <= dec_x;
            cfg_dy   <= dec_y;
            src_col  <= '0;
            src_row  <= '0;
            row_base <= '0;
            toggle   <= 1'b0;
          end
        end
        ACTIVE: begin
          if (vs_rise) begin
            state <= DONE;
            busy  <= 1'b0;
          end else begin
            if (pclk_rise && href_sync[1]) begin
              if (!toggle) begin
                b0     <= data_sync;
                toggle <= 1'b1;
              end else begin
                toggle <= 1'b0;
                if (src_col != '1)
                  src_col <= src_col + 1'b1;
                if (col_keep && row_keep && in_crop) begin
                  we   <= 1'b1;
                  addr <= pix_addr;
                  dout <= pix;
                end
              end
            end
            if (href_fall) begin
              toggle  <= 1'b0;
              src_col <= '0;
              if (src_row != '1)
                src_row <= src_row + 1'b1;
              if (row_keep)
                row_base <= row_base + ROW_STEP;
              if (toggle)
                line_err <= 1'b1;
            end
          end
        end
        DONE: begin
          frame_done <= 1'b1;
          state      <= (cap_mode == 2'b00) ? WAIT_VS : IDLE;
          if (cap_mode == 2'b01 && !arm)
            armed <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ov7670_capture_dec.sv
// tb_ov7670_capture_dec: scoreboard bench for ov7670_capture_dec with a reduced 16x8 output image.
`timescale 1ns/1ps
`default_nettype none

module tb_ov7670_capture_dec;

  localparam int COLS = 16;
  localparam int ROWS = 8;
  localparam int AW   = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pclk = 1'b0, vsync = 1'b0, href = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        rgbmode = 1'b0, swap_r_b = 1'b0, arm = 1'b0;
  logic [1:0]  dec_x = 2'd0, dec_y = 2'd0, cap_mode = 2'd0;
  logic [AW-1:0] addr;
  logic [11:0] dout;
  logic        we, frame_done, busy, line_err;

  ov7670_capture_dec #(
    .IMG_COLS(COLS), .IMG_ROWS(ROWS), .NB_ADDR(AW),
    .NB_R(4), .NB_G(4), .NB_B(4), .NB_SRC_CNT(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pclk(pclk), .vsync(vsync), .href(href), .data(data),
    .rgbmode(rgbmode), .swap_r_b(swap_r_b), .dec_x(dec_x), .dec_y(dec_y),
    .cap_mode(cap_mode), .arm(arm), .addr(addr), .dout(dout), .we(we),
    .frame_done(frame_done), .busy(busy), .line_err(line_err)
  );

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [AW+11:0] exp_q[$];
  logic [AW+11:0] obs_q[$];
  logic [AW+11:0] first_exp, first_obs;
  int fd_cnt = 0;
  int we_out_cnt = 0;
  int arm_row = -1, rst_row = -1, odd_row = -1;
  int pat = 0;
  logic [15:0] custom_pix [0:7];
  logic [AW+15:0] snap;

  always @(negedge clk) begin
    if (rst_n) begin
      if (we) obs_q.push_back({addr, dout});
      if (frame_done) fd_cnt++;
      if (we && !busy) we_out_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] model_color(input logic [7:0] c0, input logic [7:0] c1,
                                              input logic rgb, input logic sw);
    logic [3:0] r, g, b;
    if (rgb) begin
      r = c0[7:4];
      g = {c0[2:0], c1[7]};
      b = c1[4:1];
    end else begin
      r = c0[7:4];
      g = c0[7:4];
      b = c0[7:4];
    end
    return sw ? {b, g, r} : {r, g, b};
  endfunction

  task automatic drive_byte(input logic [7:0] b);
    data = b;
    pclk = 1'b0;
    tick(2);
    pclk = 1'b1;
    tick(2);
  endtask

  task automatic do_reset_mid();
    rst_n = 1'b0;
    tick(1);
    @(negedge clk);
    snap = {addr, dout, we, frame_done, busy, line_err};
    rst_n = 1'b1;
    obs_q.delete();
    fd_cnt = 0;
  endtask

  task automatic drive_frame(input int ncols, input int nrows, input bit cap);
    logic [7:0] c0, c1;
    int dx, dy, oc, orw;
    dx = int'(dec_x);
    dy = int'(dec_y);
    vsync = 1'b1;
    tick(6);
    vsync = 1'b0;
    tick(6);
    for (int r = 0; r < nrows; r++) begin
      if (r == arm_row) begin
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        tick(1);
      end
      href = 1'b1;
      for (int c = 0; c < ncols; c++) begin
        if (pat == 1) begin
          c0 = custom_pix[c][15:8];
          c1 = custom_pix[c][7:0];
        end else begin
          c0 = 8'((r << 4) ^ c);
          c1 = 8'(c * 7 + r);
        end
        drive_byte(c0);
        if (r == rst_row && c == 2) do_reset_mid();
        drive_byte(c1);
        oc  = c >> dx;
        orw = r >> dy;
        if (cap && (c % (1 << dx)) == 0 && (r % (1 << dy)) == 0 && oc < COLS && orw < ROWS)
          exp_q.push_back({AW'(orw * COLS + oc), model_color(c0, c1, rgbmode, swap_r_b)});
      end
      if (r == odd_row) drive_byte(8'h55);
      pclk = 1'b0;
      href = 1'b0;
      tick(4);
    end
    tick(4);
    vsync = 1'b1;
    tick(10);
  endtask

  task automatic score(output int nmis, output int nexp, output int nobs);
    logic [AW+11:0] e, o;
    nexp = exp_q.size();
    nobs = obs_q.size();
    nmis = 0;
    first_exp = '0;
    first_obs = '0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      if (e !== o) begin
        if (nmis == 0) begin
          first_exp = e;
          first_obs = o;
        end
        nmis++;
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    fd_cnt = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++; if (we !== 1'b0) begin fails++; $display("FAIL reset_we got %b want 0", we); end
    tests++; if (addr !== '0) begin fails++; $display("FAIL reset_addr got %0d want 0", addr); end
    tests++; if (dout !== '0) begin fails++; $display("FAIL reset_dout got %h want 000", dout); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    tests++; if (line_err !== 1'b0) begin fails++; $display("FAIL reset_line_err got %b want 0", line_err); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_continuous();
    int nm, ne, no;
    cap_mode = 2'b00; rgbmode = 1'b0; swap_r_b = 1'b0; dec_x = 2'd0; dec_y = 2'd0; pat = 0;
    clear_sb();
    drive_frame(16, 8, 1);
    drive_frame(16, 8, 1);
    score(nm, ne, no);
    tests++; if (no !== ne) begin fails++; $display("FAIL cont_count got %0d writes want %0d", no, ne); end
    tests++; if (nm !== 0) begin fails++; $display("FAIL cont_data %0d bad, got %h want %h", nm, first_obs, first_exp); end
    tests++; if (fd_cnt !== 2) begin fails++; $display("FAIL cont_frame_done got %0d want 2", fd_cnt); end
  endtask

  task automatic test_decimation();
    int nm, ne, no;
    logic [11:0] px;
    bit found;
    dec_x = 2'd1; dec_y = 2'd1; pat = 0;
    clear_sb();
    drive_frame(32, 16, 1);
    found = 1'b0;
    px = 12'h000;
    foreach (obs_q[i]) if (obs_q[i][AW+11:12] == AW'(33)) begin found = 1'b1; px = obs_q[i][11:0]; end
    tests++; if (!found || px !== 12'h444) begin fails++; $display("FAIL dec_src_2_4 found=%b got %h want 444 at addr 33", found, px); end
    score(nm, ne, no);
    tests++; if (no !== ne) begin fails++; $display("FAIL dec_count got %0d writes want %0d", no, ne); end
    tests++; if (nm !== 0) begin fails++; $display("FAIL dec_data %0d bad, got %h want %h", nm, first_obs, first_exp); end
    dec_x = 2'd0; dec_y = 2'd0;
  endtask

  task automatic test_color();
    logic [AW+11:0] g;
    pat = 1;
    rgbmode = 1'b1; swap_r_b = 1'b0;
    custom_pix[0] = 16'hF800; custom_pix[1] = 16'hF81F; custom_pix[2] = 16'h07E0;
    clear_sb();
    drive_frame(3, 1, 0);
    tests++; if (obs_q.size() !== 3) begin fails++; $display("FAIL rgb_count got %0d want 3", obs_q.size()); end
    g = (obs_q.size() > 0) ? obs_q[0] : 'x;
    tests++; if (g !== {AW'(0), 12'hF00}) begin fails++; $display("FAIL rgb_F800 got %h want addr 0 dout F00", g); end
    g = (obs_q.size() > 1) ? obs_q[1] : 'x;
    tests++; if (g !== {AW'(1), 12'hF0F}) begin fails++; $display("FAIL rgb_F81F got %h want addr 1 dout F0F", g); end
    g = (obs_q.size() > 2) ? obs_q[2] : 'x;
    tests++; if (g !== {AW'(2), 12'h0F0}) begin fails++; $display("FAIL rgb_07E0 got %h want addr 2 dout 0F0", g); end
    swap_r_b = 1'b1;
    custom_pix[0] = 16'hF800;
    clear_sb();
    drive_frame(1, 1, 0);
    g = (obs_q.size() > 0) ? obs_q[0] : 'x;
    tests++; if (g !== {AW'(0), 12'h00F}) begin fails++; $display("FAIL rgb_swap got %h want addr 0 dout 00F", g); end
    rgbmode = 1'b0; swap_r_b = 1'b0;
    custom_pix[0] = 16'hA500;
    clear_sb();
    drive_frame(1, 1, 0);
    g = (obs_q.size() > 0) ? obs_q[0] : 'x;
    tests++; if (g !== {AW'(0), 12'hAAA}) begin fails++; $display("FAIL yuv_A5 got %h want addr 0 dout AAA", g); end
    pat = 0;
    clear_sb();
  endtask

  task automatic test_single_shot();
    int nm, ne, no;
    cap_mode = 2'b01;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    clear_sb();
    arm_row = 2;
    drive_frame(16, 8, 0);
    arm_row = -1;
    tests++; if (obs_q.size() !== 0) begin fails++; $display("FAIL ss_midframe got %0d writes want 0", obs_q.size()); end
    tests++; if (fd_cnt !== 0) begin fails++; $display("FAIL ss_midframe_done got %0d want 0", fd_cnt); end
    clear_sb();
    drive_frame(16, 8, 1);
    score(nm, ne, no);
    tests++; if (no !== ne) begin fails++; $display("FAIL ss_count got %0d writes want %0d", no, ne); end
    tests++; if (nm !== 0) begin fails++; $display("FAIL ss_data %0d bad, got %h want %h", nm, first_obs, first_exp); end
    tests++; if (fd_cnt !== 1) begin fails++; $display("FAIL ss_frame_done got %0d want 1", fd_cnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ss_busy_after got %b want 0", busy); end
    clear_sb();
    drive_frame(16, 8, 0);
    tests++; if (obs_q.size() !== 0) begin fails++; $display("FAIL ss_rearm_needed got %0d writes want 0", obs_q.size()); end
    tests++; if (fd_cnt !== 0) begin fails++; $display("FAIL ss_no_second_done got %0d want 0", fd_cnt); end
    clear_sb();
  endtask

  task automatic test_line_err_crop();
    int nm, ne, no;
    cap_mode = 2'b00;
    tick(2);
    clear_sb();
    odd_row = 1;
    drive_frame(20, 4, 1);
    odd_row = -1;
    score(nm, ne, no);
    tests++; if (no !== ne) begin fails++; $display("FAIL crop_count got %0d writes want %0d", no, ne); end
    tests++; if (nm !== 0) begin fails++; $display("FAIL crop_data %0d bad, got %h want %h", nm, first_obs, first_exp); end
    tests++; if (line_err !== 1'b1) begin fails++; $display("FAIL line_err_set got %b want 1", line_err); end
    drive_frame(20, 4, 1);
    score(nm, ne, no);
    tests++; if (line_err !== 1'b1) begin fails++; $display("FAIL line_err_sticky got %b want 1", line_err); end
    tests++; if (nm !== 0 || no !== ne) begin fails++; $display("FAIL crop_frame2 bad=%0d got %0d writes want %0d", nm, no, ne); end
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    tick(2);
    tests++; if (line_err !== 1'b0) begin fails++; $display("FAIL line_err_arm_clear got %b want 0", line_err); end
  endtask

  task automatic test_reset_mid();
    int nm, ne, no;
    logic [AW-1:0] a0;
    cap_mode = 2'b00;
    clear_sb();
    snap = '1;
    rst_row = 3;
    drive_frame(16, 8, 0);
    rst_row = -1;
    tests++; if (snap !== '0) begin fails++; $display("FAIL rstmid_outputs got %h want 0", snap); end
    tests++; if (obs_q.size() !== 0) begin fails++; $display("FAIL rstmid_partial got %0d writes want 0", obs_q.size()); end
    tests++; if (fd_cnt !== 0) begin fails++; $display("FAIL rstmid_done got %0d want 0", fd_cnt); end
    clear_sb();
    drive_frame(16, 8, 1);
    a0 = (obs_q.size() > 0) ? obs_q[0][AW+11:12] : '1;
    tests++; if (a0 !== '0) begin fails++; $display("FAIL rstmid_addr0 got %0d want 0", a0); end
    score(nm, ne, no);
    tests++; if (nm !== 0 || no !== ne) begin fails++; $display("FAIL rstmid_frame bad=%0d got %0d writes want %0d", nm, no, ne); end
    tests++; if (we_out_cnt !== 0) begin fails++; $display("FAIL we_outside_active got %0d want 0", we_out_cnt); end
  endtask

  initial begin
    tick(3);
    test_reset();
    test_continuous();
    test_decimation();
    test_color();
    test_single_shot();
    test_line_err_crop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    fails++;
    $display("FAIL watchdog simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
